merge3_rr_sched: RTL

- Scheduler that merges three independent 8-bit write streams into one output stream.
- Each channel has a small buffer; a round-robin arbiter drains the buffers into a single registered output slot with valid/ren handshake.
- It is the sequencing front-end for one 3:1 merge stage of the 9:1 tree.
- Three instances feed a fourth instance in the same topology, valid to wen and o_data to i_dataN.

---
 rtl/merge3_rr_sched_pkg.sv | 26 ++
 rtl/merge3_rr_sched_fifo.sv | 62 ++++++
 rtl/merge3_rr_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/merge3_rr_sched_pkg.sv
// Shared types, constants and the round-robin helper
// for the three-channel merge scheduler.
package merge_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int NCH        = 3;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_NONE = 2'd3;

    // First requesting channel after 'last', wrapping modulo NCH; CH_NONE when idle.
    function automatic ch_idx_t rr_next(input ch_idx_t last, input logic [NCH-1:0] req);
        ch_idx_t res;
        int      c;
        res = CH_NONE;
        for (int k = 1; k <= NCH; k++) begin
            c = (int'(last) + k) % NCH;
            if ((res == CH_NONE) && req[c[1:0]]) begin
                res = ch_idx_t'(c);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/merge3_rr_sched_fifo.sv
// Single-clock per-channel FIFO; push is ignored when full and pop when empty,
// so the count can never leave 0..DEPTH.
module chan_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == (AW+1)'(0));
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/merge3_rr_sched.sv
// Three buffered write channels merged round-robin into one registered
// output slot with a valid/ren handshake and sticky per-channel overflow.
module merge3_rr_sched
    import merge_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic [NCH-1:0] wen,
    input  logic [DW-1:0]  i_data0,
    input  logic [DW-1:0]  i_data1,
    input  logic [DW-1:0]  i_data2,
    input  logic           ren,
    input  logic           freeze,
    input  logic           clr_ovf,
    output logic           valid,
    output logic [DW-1:0]  o_data,
    output logic [1:0]     o_src,
    output logic [NCH-1:0] full,
    output logic [NCH-1:0] ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  din_s   [NCH];
    logic [DW-1:0]  dout_s  [NCH];
    logic [AW:0]    count_s [NCH];
    logic [NCH-1:0] full_s, empty_s, pop_s, ovf_set_s;
    logic           slot_free_s;
    ch_idx_t        grant_s;

    logic           valid_q, valid_d;
    logic [DW-1:0]  data_q, data_d;
    ch_idx_t        src_q, src_d;
    ch_idx_t        last_q, last_d;
    logic [NCH-1:0] ovf_q, ovf_d;

    assign din_s[0] = i_data0;
    assign din_s[1] = i_data1;
    assign din_s[2] = i_data2;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .push_i  (wen[n]),
            .pop_i   (pop_s[n]),
            .din_i   (din_s[n]),
            .dout_o  (dout_s[n]),
            .full_o  (full_s[n]),
            .empty_o (empty_s[n]),
            .count_o (count_s[n])
        );
        // Overflow is judged on the registered count, so a same-cycle pop does not rescue the write.
        assign ovf_set_s[n] = wen[n] && (count_s[n] == (AW+1)'(DEPTH));
        assign pop_s[n]     = (grant_s == ch_idx_t'(n));
    end

    assign slot_free_s = !valid_q || ren;

    // Grant selection: only when the slot can take a word and draining is enabled.
    always_comb begin
        grant_s = CH_NONE;
        if (slot_free_s && !freeze) begin
            grant_s = rr_next(last_q, ~empty_s);
        end else begin
            grant_s = CH_NONE;
        end
    end

    // Output slot, arbiter pointer and overflow next state.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        if (slot_free_s) begin
            if (grant_s != CH_NONE) begin
                valid_d = 1'b1;
                src_d   = grant_s;
                last_d  = grant_s;
                case (grant_s)
                    2'd0:    data_d = dout_s[0];
                    2'd1:    data_d = dout_s[1];
                    2'd2:    data_d = dout_s[2];
                    default: data_d = data_q;
                endcase
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
        ovf_d = (clr_ovf ? {NCH{1'b0}} : ovf_q) | ovf_set_s;
    end

    // Output slot, arbiter pointer and overflow registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 2'd0;
            last_q  <= 2'd2;
            ovf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid  = valid_q;
    assign o_data = data_q;
    assign o_src  = src_q;
    assign full   = full_s;
    assign ovf    = ovf_q;

endmodule
